emif_csr_responder: RTL and testbench

//  - CSR responder for the EMIF feature: serves DFH, STATUS, CAPABILITY and SCRATCH to the host CSR master.
//  - Sits behind the FME/port CSR fabric at the EMIF feature base; this is the slave end of the bus the CSR tests read.
//  - Synchronises per-channel calibration flags from the EMIF domain and keeps sticky failure/timeout status.

---
 rtl/emif_csr_if.sv | 15 +
 rtl/emif_csr_responder.sv | 104 ++++++++++
 tb/tb_emif_csr_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/emif_csr_if.sv
// emif_csr_if: host CSR bus between the CSR fabric master and the EMIF feature responder
interface emif_csr_if #(parameter int ADDR_W = 8);
  logic              csr_read;
  logic              csr_write;
  logic [ADDR_W-1:0] csr_addr;
  logic [63:0]       csr_wdata;
  logic [7:0]        csr_wstrb;
  logic              csr_waitrequest;
  logic [63:0]       csr_rdata;
  logic              csr_rvalid;
  modport master (output csr_read, csr_write, csr_addr, csr_wdata, csr_wstrb,
                  input  csr_waitrequest, csr_rdata, csr_rvalid);
  modport slave  (input  csr_read, csr_write, csr_addr, csr_wdata, csr_wstrb,
                  output csr_waitrequest, csr_rdata, csr_rvalid);
endinterface

// File: rtl/emif_csr_responder.sv
// emif_csr_responder: EMIF feature CSR slave serving DFH, STATUS, CAPABILITY and SCRATCH.
// Define EMIF_CSR_CAL_TIMEOUT_EN to add the calibration timeout counter behind STATUS[16].
module emif_csr_responder #(
  parameter int                    NUM_MEM_CH         = 4,
  parameter logic [NUM_MEM_CH-1:0] CH_PRESENT         = 4'hF,
  parameter int                    ADDR_W             = 8,
  parameter logic [3:0]            DFH_FEAT_TYPE      = 4'h3,
  parameter logic [3:0]            DFH_MAJOR          = 4'h1,
  parameter logic [3:0]            DFH_MINOR          = 4'h0,
  parameter logic                  DFH_EOL            = 1'b0,
  parameter logic [23:0]           DFH_NEXT_OFFSET    = 24'h00B000,
  parameter logic [11:0]           DFH_FEAT_ID        = 12'h009,
  parameter logic [31:0]           CAL_TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  emif_csr_if.slave             csr,
  input  logic [NUM_MEM_CH-1:0] cal_success,
  input  logic [NUM_MEM_CH-1:0] cal_fail
);
  localparam int IW = ADDR_W - 3;
  localparam logic [63:0] DFH = {DFH_FEAT_TYPE, 8'h0, DFH_MINOR, 7'h0, DFH_EOL,
                                 DFH_NEXT_OFFSET, DFH_MAJOR, DFH_FEAT_ID};
  typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;
  state_t                r_state, w_next;
  logic                  w_rd, w_wr, w_st_wr, w_sc_wr, w_to, w_unused;
  logic [IW-1:0]         w_idx;
  logic [63:0]           w_bmask, w_wd, w_status, w_rmux, r_rdata, r_scratch;
  logic [NUM_MEM_CH-1:0] r_succ_s1, r_succ_s2, r_fail_s1, r_fail_s2, r_fail_sticky;
  // INIT holds off the first cycle after reset release
  always_comb begin
    w_next              = r_state;
    csr.csr_waitrequest = 1'b1;
    csr.csr_rvalid      = 1'b0;
    w_rd                = 1'b0;
    w_wr                = 1'b0;
    if (r_state == INIT) begin
      w_next = IDLE;
    end else if (r_state == RESP) begin
      w_next         = IDLE;
      csr.csr_rvalid = 1'b1;
    end else begin
      csr.csr_waitrequest = 1'b0;
      w_wr                = csr.csr_write;
      w_rd                = csr.csr_read & ~csr.csr_write;
      w_next              = w_rd ? RESP : IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= INIT;
    else        r_state <= w_next;
  always_comb begin
    w_idx = csr.csr_addr[ADDR_W-1:3];
    for (int b = 0; b < 8; b++) w_bmask[b*8+:8] = {8{csr.csr_wstrb[b]}};
    w_wd     = csr.csr_wdata & w_bmask;
    w_st_wr  = w_wr && w_idx == IW'(1);
    w_sc_wr  = w_wr && w_idx == IW'(3);
    w_status = 64'(r_succ_s2) | (64'(r_fail_sticky) << 8) | (64'(w_to) << 16);
    w_rmux   = w_idx == IW'(0) ? DFH :
               w_idx == IW'(1) ? w_status :
               w_idx == IW'(2) ? 64'(CH_PRESENT) :
               w_idx == IW'(3) ? r_scratch : 64'h0;
  end
  assign csr.csr_rdata = r_rdata;
  // Hardware set of the sticky fail bits takes priority over a same-cycle W1C
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_succ_s1     <= '0;
      r_succ_s2     <= '0;
      r_fail_s1     <= '0;
      r_fail_s2     <= '0;
      r_fail_sticky <= '0;
      r_scratch     <= '0;
      r_rdata       <= '0;
    end else begin
      r_succ_s1     <= cal_success;
      r_succ_s2     <= r_succ_s1;
      r_fail_s1     <= cal_fail;
      r_fail_s2     <= r_fail_s1;
      r_fail_sticky <= (r_fail_sticky & ~(w_st_wr ? w_wd[8+:NUM_MEM_CH] : '0)) | r_fail_s2;
      if (w_sc_wr) r_scratch <= (r_scratch & ~w_bmask) | w_wd;
      if (w_rd)    r_rdata   <= w_rmux;
    end
`ifdef EMIF_CSR_CAL_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_to, w_to_clr, w_pend;
  assign w_to_clr = w_st_wr & w_wd[16];
  assign w_pend   = (|(CH_PRESENT & ~r_succ_s2)) & ~(|r_fail_sticky);
  assign w_to     = r_to;
  // Counter saturates at the limit; the flag is raised on the step that reaches it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_to     <= 1'b0;
    end else begin
      r_to <= (r_to & ~w_to_clr) | (w_pend && r_to_cnt == CAL_TIMEOUT_CYCLES - 32'd1);
      if (w_to_clr)                                     r_to_cnt <= '0;
      else if (w_pend && r_to_cnt != CAL_TIMEOUT_CYCLES) r_to_cnt <= r_to_cnt + 32'd1;
    end
`else
  assign w_to = 1'b0;
`endif
  assign w_unused = ^{csr.csr_addr[2:0], CAL_TIMEOUT_CYCLES};
endmodule

// File: tb/tb_emif_csr_responder.sv
// tb_emif_csr_responder: directed checks of the EMIF CSR responder (register map, sync, sticky, timeout).
module tb_emif_csr_responder;
`ifdef EMIF_CSR_CAL_TIMEOUT_EN
  localparam logic TO_ON = 1'b1;
`else
  localparam logic TO_ON = 1'b0;
`endif
  localparam logic [63:0] SM = TO_ON ? ~64'h1_0000 : ~64'h0;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] cal_success = '0, cal_fail = '0;
  int n_tests = 0, n_fail = 0;
  emif_csr_if #(.ADDR_W(8)) bus();
  emif_csr_responder #(.CAL_TIMEOUT_CYCLES(32'd100)) dut (
    .clk(clk), .rst_n(rst_n), .csr(bus.slave),
    .cal_success(cal_success), .cal_fail(cal_fail));
  always #5 clk = ~clk;

  task automatic do_read(input logic [7:0] a, output logic [63:0] d, output logic ok);
    int n = 0;
    ok = 1'b0; d = '0;
    bus.csr_read = 1'b1; bus.csr_addr = a;
    @(negedge clk);
    while (bus.csr_waitrequest && n < 20) begin @(negedge clk); n++; end
    if (!bus.csr_waitrequest) begin
      @(posedge clk); #1 bus.csr_read = 1'b0;
      @(negedge clk); ok = bus.csr_rvalid; d = bus.csr_rdata;
      @(posedge clk); #1;
    end else bus.csr_read = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [63:0] wd, input logic [7:0] s);
    int n = 0;
    bus.csr_write = 1'b1; bus.csr_addr = a; bus.csr_wdata = wd; bus.csr_wstrb = s;
    @(negedge clk);
    while (bus.csr_waitrequest && n < 20) begin @(negedge clk); n++; end
    if (bus.csr_waitrequest) begin n_tests++; n_fail++; $display("FAIL write_accept addr %h never accepted", a); end
    @(posedge clk); #1 bus.csr_write = 1'b0;
  endtask

  task automatic test_reset;
    bus.csr_read = 0; bus.csr_write = 0; bus.csr_addr = '0; bus.csr_wdata = '0; bus.csr_wstrb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.csr_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_wait got %b exp 1", bus.csr_waitrequest); end
    n_tests++; if (bus.csr_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got %b exp 0", bus.csr_rvalid); end
    n_tests++; if (bus.csr_rdata !== 64'h0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", bus.csr_rdata); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.csr_waitrequest !== 1'b1) begin n_fail++; $display("FAIL first_clk_wait got %b exp 1", bus.csr_waitrequest); end
    @(negedge clk);
    n_tests++; if (bus.csr_waitrequest !== 1'b0) begin n_fail++; $display("FAIL idle_wait got %b exp 0", bus.csr_waitrequest); end
    @(posedge clk); #1;
  endtask

  task automatic test_ro_map;
    logic [63:0] d; logic ok;
    do_read(8'h00, d, ok);
    n_tests++; if (ok !== 1'b1 || d !== 64'h3000_0000_B000_1009) begin n_fail++; $display("FAIL dfh got ok=%b %h exp 3000_0000_B000_1009", ok, d); end
    @(negedge clk);
    n_tests++; if (bus.csr_rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_single got %b exp 0", bus.csr_rvalid); end
    @(posedge clk); #1;
    do_read(8'h05, d, ok);
    n_tests++; if (ok !== 1'b1 || d !== 64'h3000_0000_B000_1009) begin n_fail++; $display("FAIL dfh_lowbits got %h exp 3000_0000_B000_1009", d); end
    do_read(8'h10, d, ok);
    n_tests++; if (ok !== 1'b1 || d !== 64'hF) begin n_fail++; $display("FAIL capability got %h exp f", d); end
    do_read(8'h20, d, ok);
    n_tests++; if (ok !== 1'b1 || d !== 64'h0) begin n_fail++; $display("FAIL unmapped_20 got %h exp 0", d); end
    do_read(8'hF8, d, ok);
    n_tests++; if (ok !== 1'b1 || d !== 64'h0) begin n_fail++; $display("FAIL unmapped_f8 got %h exp 0", d); end
  endtask

  task automatic test_status_sync;
    logic [63:0] d; logic ok;
    cal_success = 4'b0101;
    repeat (2) @(posedge clk); #1;
    do_read(8'h08, d, ok);
    n_tests++; if (ok !== 1'b1 || (d & SM) !== 64'h5) begin n_fail++; $display("FAIL sync_0101 got %h exp 5", d); end
    cal_success = 4'b1111;
    repeat (2) @(posedge clk); #1;
    do_read(8'h08, d, ok);
    n_tests++; if (ok !== 1'b1 || (d & SM) !== 64'hF) begin n_fail++; $display("FAIL sync_1111 got %h exp f", d); end
  endtask

  task automatic test_sticky_fail;
    logic [63:0] d; logic ok;
    cal_success = 4'b0000;
    cal_fail = 4'b0100;
    repeat (2) @(posedge clk); #1 cal_fail = 4'b0000;
    repeat (4) @(posedge clk); #1;
    do_read(8'h08, d, ok);
    n_tests++; if (ok !== 1'b1 || (d & SM) !== 64'h400) begin n_fail++; $display("FAIL sticky_set got %h exp 400", d); end
    do_write(8'h08, 64'h400, 8'h01);
    do_read(8'h08, d, ok);
    n_tests++; if ((d & SM) !== 64'h400) begin n_fail++; $display("FAIL w1c_strb_off got %h exp 400", d); end
    do_write(8'h08, 64'h400, 8'h02);
    do_read(8'h08, d, ok);
    n_tests++; if ((d & SM) !== 64'h0) begin n_fail++; $display("FAIL w1c_clear got %h exp 0", d); end
    cal_fail = 4'b0100;
    @(posedge clk); #1;
    @(posedge clk); #1 cal_fail = 4'b0000;
    @(posedge clk); #1;
    do_write(8'h08, 64'h400, 8'h02);
    do_read(8'h08, d, ok);
    n_tests++; if ((d & SM) !== 64'h400) begin n_fail++; $display("FAIL set_wins got %h exp 400", d); end
    do_write(8'h08, 64'h400, 8'h02);
    do_read(8'h08, d, ok);
    n_tests++; if ((d & SM) !== 64'h0) begin n_fail++; $display("FAIL w1c_reclear got %h exp 0", d); end
  endtask

  task automatic test_scratch;
    logic [63:0] d; logic ok;
    do_write(8'h18, 64'hDEAD_BEEF_0123_4567, 8'h0F);
    do_read(8'h18, d, ok);
    n_tests++; if (ok !== 1'b1 || d !== 64'h0000_0000_0123_4567) begin n_fail++; $display("FAIL scratch_lo got %h exp 0000_0000_0123_4567", d); end
    do_write(8'h18, 64'h1111_2222_3333_4444, 8'hF0);
    do_read(8'h18, d, ok);
    n_tests++; if (d !== 64'h1111_2222_0123_4567) begin n_fail++; $display("FAIL scratch_hi got %h exp 1111_2222_0123_4567", d); end
    do_write(8'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    do_read(8'h18, d, ok);
    n_tests++; if (d !== 64'h1111_2222_0123_4567) begin n_fail++; $display("FAIL unmapped_write got %h exp 1111_2222_0123_4567", d); end
  endtask

  task automatic test_rw_collision;
    logic [63:0] d; logic ok; int rv = 0;
    bus.csr_read = 1'b1;
    do_write(8'h18, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF);
    bus.csr_read = 1'b0;
    repeat (2) begin @(negedge clk); rv += int'(bus.csr_rvalid); end
    n_tests++; if (rv !== 0) begin n_fail++; $display("FAIL collision_rvalid got %0d exp 0", rv); end
    @(posedge clk); #1;
    do_read(8'h18, d, ok);
    n_tests++; if (d !== 64'hA5A5_5A5A_0F0F_F0F0) begin n_fail++; $display("FAIL collision_write got %h exp a5a5_5a5a_0f0f_f0f0", d); end
  endtask

  task automatic test_back_to_back;
    int rv = 0, wt = 0;
    bus.csr_read = 1'b1; bus.csr_addr = 8'h10;
    repeat (6) begin @(negedge clk); rv += int'(bus.csr_rvalid); wt += int'(bus.csr_waitrequest); end
    @(posedge clk); #1 bus.csr_read = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (rv !== 3) begin n_fail++; $display("FAIL b2b_rvalid_count got %0d exp 3", rv); end
    n_tests++; if (wt !== 3) begin n_fail++; $display("FAIL b2b_wait_count got %0d exp 3", wt); end
  endtask

  task automatic test_mid_reset;
    logic [63:0] d; logic ok;
    bus.csr_read = 1'b1; bus.csr_addr = 8'h00;
    @(posedge clk); #1 bus.csr_read = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.csr_rvalid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got %b exp 1", bus.csr_rvalid); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.csr_rvalid !== 1'b0 || bus.csr_waitrequest !== 1'b1) begin n_fail++; $display("FAIL midrst_drop rvalid=%b wait=%b exp 0/1", bus.csr_rvalid, bus.csr_waitrequest); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.csr_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_lost got %b exp 0", bus.csr_rvalid); end
    @(posedge clk); #1;
    do_read(8'h18, d, ok);
    n_tests++; if (ok !== 1'b1 || d !== 64'h0) begin n_fail++; $display("FAIL scratch_reset got %h exp 0", d); end
  endtask

  task automatic test_timeout;
    logic [63:0] d; logic ok;
    cal_success = 4'b0000; cal_fail = 4'b0000;
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    repeat (85) @(posedge clk); #1;
    do_read(8'h08, d, ok);
    n_tests++; if (d !== 64'h0) begin n_fail++; $display("FAIL to_early got %h exp 0", d); end
    repeat (20) @(posedge clk); #1;
    do_read(8'h08, d, ok);
    n_tests++; if (d !== (TO_ON ? 64'h1_0000 : 64'h0)) begin n_fail++; $display("FAIL to_set got %h exp %h", d, TO_ON ? 64'h1_0000 : 64'h0); end
    do_write(8'h08, 64'h1_0000, 8'h04);
    do_read(8'h08, d, ok);
    n_tests++; if (d !== 64'h0) begin n_fail++; $display("FAIL to_clear got %h exp 0", d); end
    repeat (80) @(posedge clk); #1;
    do_read(8'h08, d, ok);
    n_tests++; if (d !== 64'h0) begin n_fail++; $display("FAIL to_restart got %h exp 0", d); end
    repeat (30) @(posedge clk); #1;
    do_read(8'h08, d, ok);
    n_tests++; if (d !== (TO_ON ? 64'h1_0000 : 64'h0)) begin n_fail++; $display("FAIL to_reset_again got %h exp %h", d, TO_ON ? 64'h1_0000 : 64'h0); end
  endtask

  initial begin
    test_reset();
    test_ro_map();
    test_status_sync();
    test_sticky_fail();
    test_scratch();
    test_rw_collision();
    test_back_to_back();
    test_mid_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
